// File: rtl/palette_lut.sv
// Multi-bank runtime-writable colour palette with frame-synchronous bank/fade commit.
// Two-stage lookup: stage 1 reads the entry and latches fade, stage 2 applies brightness.

module palette_fade_ch (
  input  logic [7:0] chan,
  input  logic [7:0] fade,
  output logic [7:0] scaled
);
  logic [8:0]  fade_p1;
  logic [16:0] prod;
  logic        unused_bits;

  // (fade + 1) makes 255 an exact identity and 0 a hard black
  assign fade_p1     = {1'b0, fade} + 9'd1;
  assign prod        = {9'd0, chan} * {8'd0, fade_p1};
  assign scaled      = prod[15:8];
  assign unused_bits = ^{prod[16], prod[7:0]};
endmodule

module palette_lut #(
  parameter  int INDEX_W = 4,
  parameter  int BANKS   = 2,
  localparam int BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_valid,
  input  logic [INDEX_W-1:0] i_pix_index,
  output logic               o_pix_valid,
  output logic [23:0]        o_pix_rgb,
  input  logic               i_wr_en,
  input  logic [BANK_W-1:0]  i_wr_bank,
  input  logic [INDEX_W-1:0] i_wr_addr,
  input  logic [23:0]        i_wr_data,
  input  logic [BANK_W-1:0]  i_bank_sel,
  input  logic [7:0]         i_fade,
  input  logic               i_frame_start,
  output logic [BANK_W-1:0]  o_active_bank
);
  localparam int DEPTH = 1 << INDEX_W;

  function automatic logic [23:0] reset_rgb(int b, int e);
    logic [23:0] v;
    v = '0;
    if (b == 0) begin
      case (e)
        0:  v = 24'hf9f8f8;  1: v = 24'hadd8e6;  2: v = 24'hd1d0cf;  3: v = 24'he6c8a0;
        4:  v = 24'hdcbe96;  5: v = 24'hc3c2bf;  6: v = 24'hd2b48c;  7: v = 24'hbdbbb9;
        8:  v = 24'h979492;  9: v = 24'h787878; 10: v = 24'h6e6e6e; 11: v = 24'h646464;
        12: v = 24'h55514c; 13: v = 24'h515151; 14: v = 24'h2c2721; 15: v = 24'h010101;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  logic [23:0]       mem [BANKS][DEPTH];
  logic [BANK_W-1:0] active_bank;
  logic [7:0]        active_fade;
  logic [1:0]        vld_pipe;
  logic [23:0]       s1_rgb;
  logic [7:0]        s1_fade;
  logic [23:0]       faded;

  // Flop-based storage so reset can restore every bank; out-of-range banks match no entry.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
      always_ff @(posedge i_clk) begin
        if (i_rst)
          mem[b][e] <= reset_rgb(b, e);
        else if (i_wr_en && i_wr_bank == BANK_W'(b) && i_wr_addr == INDEX_W'(e))
          mem[b][e] <= i_wr_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active_bank <= '0;
      active_fade <= 8'hff;
    end else if (i_frame_start) begin
      active_fade <= i_fade;
      if (int'(i_bank_sel) < BANKS)
        active_bank <= i_bank_sel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe  <= '0;
      s1_rgb    <= '0;
      s1_fade   <= 8'hff;
      o_pix_rgb <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], i_pix_valid};
      if (i_pix_valid) begin
        s1_rgb  <= mem[active_bank][i_pix_index];
        s1_fade <= active_fade;
      end
      if (vld_pipe[0])
        o_pix_rgb <= faded;
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    palette_fade_ch u_ch (
      .chan   (s1_rgb[c*8 +: 8]),
      .fade   (s1_fade),
      .scaled (faded[c*8 +: 8])
    );
  end

  assign o_pix_valid   = vld_pipe[1];
  assign o_active_bank = active_bank;
endmodule

// File: tb/tb_palette_lut.sv
// Scoreboard bench for palette_lut: stimulus pushes expected colours, a negedge monitor pops them.

module tb_palette_lut;
  localparam int INDEX_W = 4;
  localparam int BANKS   = 3;
  localparam int BANK_W  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               pix_valid;
  logic [INDEX_W-1:0] pix_index;
  logic               out_valid;
  logic [23:0]        out_rgb;
  logic               wr_en;
  logic [BANK_W-1:0]  wr_bank;
  logic [INDEX_W-1:0] wr_addr;
  logic [23:0]        wr_data;
  logic [BANK_W-1:0]  bank_sel;
  logic [7:0]         fade;
  logic               frame_start;
  logic [BANK_W-1:0]  active_bank;

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q [$];

  always #5 clk = ~clk;

  palette_lut #(.INDEX_W(INDEX_W), .BANKS(BANKS)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_pix_valid(pix_valid), .i_pix_index(pix_index),
    .o_pix_valid(out_valid), .o_pix_rgb(out_rgb),
    .i_wr_en(wr_en), .i_wr_bank(wr_bank), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_bank_sel(bank_sel), .i_fade(fade), .i_frame_start(frame_start),
    .o_active_bank(active_bank)
  );

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %06h expected none", out_rgb);
      end else begin
        chk("lookup", out_rgb, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pix_valid   = 1'b0;
    wr_en       = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic lookup(input int idx, input logic [23:0] exp);
    pix_valid = 1'b1;
    pix_index = INDEX_W'(idx);
    exp_q.push_back(exp);
  endtask

  task automatic write(input int bank, input int addr, input logic [23:0] data);
    wr_en   = 1'b1;
    wr_bank = BANK_W'(bank);
    wr_addr = INDEX_W'(addr);
    wr_data = data;
  endtask

  task automatic commit(input int bank, input logic [7:0] f);
    frame_start = 1'b1;
    bank_sel    = BANK_W'(bank);
    fade        = f;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; pix_valid = 0; pix_index = '0; wr_en = 0; wr_bank = '0; wr_addr = '0;
    wr_data = '0; bank_sel = '0; fade = 8'hff; frame_start = 0;
    idle(2);
    rst = 1'b0;
    chk("reset_valid", {23'd0, out_valid}, 24'd0);
    chk("reset_rgb", out_rgb, 24'h000000);
    chk("reset_bank", {22'd0, active_bank}, 24'd0);

    // reset palette, back-to-back
    lookup(1, 24'hadd8e6);  tick();
    lookup(15, 24'h010101); tick();
    idle(3);
    chk("bubble_valid", {23'd0, out_valid}, 24'd0);
    chk("bubble_hold", out_rgb, 24'h010101);

    // load bank 1 and switch to it
    write(1, 3, 24'h123456); tick();
    commit(1, 8'hff);        tick();
    chk("active_bank_1", {22'd0, active_bank}, 24'd1);
    lookup(3, 24'h123456); tick();
    lookup(4, 24'h000000); tick();
    idle(3);

    // fade, including commit coinciding with a lookup
    commit(0, 8'd128);       tick();
    lookup(0, 24'h7d7c7c);   tick();
    commit(0, 8'd0);
    lookup(0, 24'h7d7c7c);   tick();
    lookup(0, 24'h000000);   tick();
    commit(0, 8'hff);        tick();
    lookup(0, 24'hf9f8f8);   tick();
    idle(3);

    // write/lookup collision
    write(0, 15, 24'hffffff);
    lookup(15, 24'h010101);  tick();
    lookup(15, 24'hffffff);  tick();
    idle(3);

    // bank commit coinciding with lookup, then out-of-range bank_sel
    commit(1, 8'hff);
    lookup(0, 24'hf9f8f8);   tick();
    lookup(0, 24'h000000);   tick();
    chk("active_bank_commit", {22'd0, active_bank}, 24'd1);
    commit(3, 8'd128);       tick();
    chk("bank_sel_oob", {22'd0, active_bank}, 24'd1);
    lookup(3, 24'h091a2b);   tick();
    commit(2, 8'hff);        tick();
    chk("active_bank_2", {22'd0, active_bank}, 24'd2);
    lookup(3, 24'h000000);   tick();
    idle(3);

    // reset drops the in-flight lookup and the earlier write
    write(0, 2, 24'habcdef); tick();
    pix_valid = 1'b1; pix_index = 4'd2; tick();
    rst = 1'b1; tick();
    chk("rst_valid", {23'd0, out_valid}, 24'd0);
    chk("rst_rgb", out_rgb, 24'h000000);
    chk("rst_bank", {22'd0, active_bank}, 24'd0);
    rst = 1'b0;
    lookup(2, 24'hd1d0cf);   tick();
    lookup(15, 24'h010101);  tick();
    idle(4);

    chk("queue_drained", 24'(exp_q.size()), 24'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
